// File: rtl/gpu_pkg.sv
// Shared GPU types: the 32-bit sprite descriptor layout and its reset/invisible encodings.
package gpu_pkg;

    localparam int Y_LSB     = 22;
    localparam int X_LSB     = 12;
    localparam int FLAGS_LSB = 6;
    localparam int IMG_LSB   = 0;
    localparam int Y_W       = 10;
    localparam int X_W       = 10;
    localparam int FLAGS_W   = 6;
    localparam int IMG_W     = 6;

    typedef struct packed {
        logic [Y_W-1:0]     y;
        logic [X_W-1:0]     x;
        logic [FLAGS_W-1:0] flags;
        logic [IMG_W-1:0]   img;
    } sprite_desc_t;

    localparam logic [FLAGS_W-1:0] INVISIBLE_FLAGS = 6'h3F;
    localparam logic [31:0]        DESC_RESET      = 32'h0000_0FC0;

    function automatic sprite_desc_t unpack_desc(input logic [31:0] raw);
        sprite_desc_t d;
        d.y     = raw[Y_LSB +: Y_W];
        d.x     = raw[X_LSB +: X_W];
        d.flags = raw[FLAGS_LSB +: FLAGS_W];
        d.img   = raw[IMG_LSB +: IMG_W];
        return d;
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Bounding-box hit test of one sprite against the current pixel, with in-sprite offsets.
module sprite_hit_unit
    import gpu_pkg::*;
#(
    parameter int SIZE_LOG2 = 5
) (
    input  sprite_desc_t          desc,
    input  logic [9:0]            sys_x,
    input  logic [9:0]            sys_y,
    output logic                  hit,
    output logic [SIZE_LOG2-1:0]  dx,
    output logic [SIZE_LOG2-1:0]  dy,
    output logic [IMG_W-1:0]      img
);

    localparam logic [10:0] EDGE = 11'(2 ** SIZE_LOG2);

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x_lo;
    logic [10:0] y_lo;

    // 11-bit compares let a sprite near 1023 clip instead of wrapping to column 0
    always_comb begin
        px   = {1'b0, sys_x};
        py   = {1'b0, sys_y};
        x_lo = {1'b0, desc.x};
        y_lo = {1'b0, desc.y};
        hit  = (desc.flags != INVISIBLE_FLAGS)
             && (px >= x_lo) && (px < x_lo + EDGE)
             && (py >= y_lo) && (py < y_lo + EDGE);
        dx   = sys_x[SIZE_LOG2-1:0] - desc.x[SIZE_LOG2-1:0];
        dy   = sys_y[SIZE_LOG2-1:0] - desc.y[SIZE_LOG2-1:0];
        img  = desc.img;
    end

endmodule

// File: rtl/sprite_layer_bank.sv
// Double-buffered sprite descriptor bank with per-pixel priority hit test, two-stage
// ROM composite pipeline and a sticky bounding-box collision flag.
module sprite_layer_bank
    import gpu_pkg::*;
#(
    parameter int                 N_SPRITES   = 4,
    parameter int                 SIZE_LOG2   = 5,
    parameter int                 PIXEL_W     = 16,
    parameter logic [PIXEL_W-1:0] TRANSPARENT = '0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           WRITE,
    input  logic [$clog2(N_SPRITES)-1:0]   WRITE_ADDR,
    input  logic [31:0]                    WRITE_DATA,
    input  logic                           FRAME_START,
    input  logic [9:0]                     SYS_X,
    input  logic [9:0]                     SYS_Y,
    input  logic                           PIXEL_VALID,
    input  logic [PIXEL_W-1:0]             BG_DATA,
    output logic [6+2*SIZE_LOG2-1:0]       ROM_ADDR,
    input  logic [PIXEL_W-1:0]             ROM_DATA,
    output logic [PIXEL_W-1:0]             OUT_GRAPHIC_DATA,
    output logic                           OUT_VALID,
    output logic                           COLLISION,
    input  logic                           COLLISION_CLR
);

    localparam int AW   = $clog2(N_SPRITES);
    localparam int RA_W = 6 + 2 * SIZE_LOG2;

    sprite_desc_t shadow_q [N_SPRITES];
    sprite_desc_t shadow_d [N_SPRITES];
    sprite_desc_t active_q [N_SPRITES];
    sprite_desc_t active_d [N_SPRITES];

    logic [N_SPRITES-1:0]  hit;
    logic [SIZE_LOG2-1:0]  dx  [N_SPRITES];
    logic [SIZE_LOG2-1:0]  dy  [N_SPRITES];
    logic [IMG_W-1:0]      img [N_SPRITES];

    logic                  win_found;
    logic [RA_W-1:0]       win_addr;
    logic                  multi_hit;

    logic [RA_W-1:0]       rom_addr_q, rom_addr_d;
    logic                  hit_q, hit_d;
    logic                  valid_q, valid_d;
    logic [PIXEL_W-1:0]    bg_q, bg_d;
    logic [PIXEL_W-1:0]    out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  collision_q, collision_d;

    // A write landing on the commit cycle is forwarded straight into the active copy
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (WRITE && (WRITE_ADDR == AW'(i))) begin
                shadow_d[i] = unpack_desc(WRITE_DATA);
            end
        end
        if (FRAME_START) begin
            active_d = shadow_d;
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
        sprite_hit_unit #(
            .SIZE_LOG2 (SIZE_LOG2)
        ) u_hit (
            .desc  (active_q[g]),
            .sys_x (SYS_X),
            .sys_y (SYS_Y),
            .hit   (hit[g]),
            .dx    (dx[g]),
            .dy    (dy[g]),
            .img   (img[g])
        );
    end

    always_comb begin
        win_found = 1'b0;
        win_addr  = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_found = 1'b1;
                win_addr  = {img[i], dy[i], dx[i]};
            end
        end
        multi_hit = (hit & (hit - N_SPRITES'(1))) != '0;
    end

    always_comb begin
        rom_addr_d  = win_addr;
        hit_d       = win_found;
        bg_d        = BG_DATA;
        valid_d     = PIXEL_VALID;
        out_valid_d = valid_q;
        out_data_d  = (hit_q && (ROM_DATA != TRANSPARENT)) ? ROM_DATA : bg_q;
        collision_d = collision_q;
        if (COLLISION_CLR) begin
            collision_d = 1'b0;
        end
        if (PIXEL_VALID && multi_hit) begin
            collision_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow_q[i] <= DESC_RESET;
                active_q[i] <= DESC_RESET;
            end
            rom_addr_q  <= '0;
            hit_q       <= 1'b0;
            valid_q     <= 1'b0;
            bg_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            rom_addr_q  <= rom_addr_d;
            hit_q       <= hit_d;
            valid_q     <= valid_d;
            bg_q        <= bg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            collision_q <= collision_d;
        end
    end

    assign ROM_ADDR         = rom_addr_q;
    assign OUT_GRAPHIC_DATA = out_data_q;
    assign OUT_VALID        = out_valid_q;
    assign COLLISION        = collision_q;

endmodule

// File: tb/tb_sprite_layer_bank.sv
// Directed bench for sprite_layer_bank: a descriptor-level model predicts every output
// each cycle, and literal expectations pin the model at the interesting points.
module tb_sprite_layer_bank;

    localparam int N   = 4;
    localparam int S   = 5;
    localparam int EDG = 1 << S;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WRITE = 1'b0;
    logic [1:0]  WRITE_ADDR = '0;
    logic [31:0] WRITE_DATA = '0;
    logic        FRAME_START = 1'b0;
    logic [9:0]  SYS_X = '0;
    logic [9:0]  SYS_Y = '0;
    logic        PIXEL_VALID = 1'b0;
    logic [15:0] BG_DATA = '0;
    logic [15:0] ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic [15:0] OUT_GRAPHIC_DATA;
    logic        OUT_VALID;
    logic        COLLISION;
    logic        COLLISION_CLR = 1'b0;

    logic [15:0] rom_mem [0:65535];
    assign ROM_DATA = rom_mem[ROM_ADDR];

    always #5 CLK = ~CLK;

    sprite_layer_bank #(
        .N_SPRITES   (N),
        .SIZE_LOG2   (S),
        .PIXEL_W     (16),
        .TRANSPARENT (16'h0000)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .WRITE            (WRITE),
        .WRITE_ADDR       (WRITE_ADDR),
        .WRITE_DATA       (WRITE_DATA),
        .FRAME_START      (FRAME_START),
        .SYS_X            (SYS_X),
        .SYS_Y            (SYS_Y),
        .PIXEL_VALID      (PIXEL_VALID),
        .BG_DATA          (BG_DATA),
        .ROM_ADDR         (ROM_ADDR),
        .ROM_DATA         (ROM_DATA),
        .OUT_GRAPHIC_DATA (OUT_GRAPHIC_DATA),
        .OUT_VALID        (OUT_VALID),
        .COLLISION        (COLLISION),
        .COLLISION_CLR    (COLLISION_CLR)
    );

    int n_checks = 0;
    int n_errors = 0;

    int sh_y [N], sh_x [N], sh_f [N], sh_i [N];
    int act_y [N], act_x [N], act_f [N], act_i [N];

    bit          s1_valid, s1_hit;
    int          s1_addr;
    logic [15:0] s1_bg;
    int          exp_addr;
    bit          exp_coll, exp_out_v, force_zero;
    logic [15:0] exp_out;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] desc(input int y, input int x, input int f, input int im);
        return {10'(y), 10'(x), 6'(f), 6'(im)};
    endfunction

    function automatic bit model_hit(input int s, input int x, input int y);
        return (act_f[s] != 63) && (x >= act_x[s]) && (x < act_x[s] + EDG)
            && (y >= act_y[s]) && (y < act_y[s] + EDG);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            sh_y[s] = 0;  sh_x[s] = 0;  sh_f[s] = 63;  sh_i[s] = 0;
            act_y[s] = 0; act_x[s] = 0; act_f[s] = 63; act_i[s] = 0;
        end
        s1_valid = 0; s1_hit = 0; s1_addr = 0; s1_bg = '0;
        exp_addr = 0; exp_coll = 0; exp_out_v = 0; exp_out = '0;
        force_zero = 1;
    endtask

    task automatic checkOutput();
        check("rom_addr", 32'(ROM_ADDR), 32'(exp_addr));
        check("collision", 32'(COLLISION), 32'(exp_coll));
        check("out_valid", 32'(OUT_VALID), 32'(exp_out_v));
        if (exp_out_v || force_zero) begin
            check("out_data", 32'(OUT_GRAPHIC_DATA), 32'(exp_out));
        end
    endtask

    // Drive one cycle of inputs, advance the model over the coming edge, then compare
    task automatic applyStimulus(input int x, input int y, input logic [15:0] bg, input bit v,
                                 input bit wr, input int wa, input logic [31:0] wd,
                                 input bit fs, input bit clr);
        int          win;
        int          cnt;
        int          n_addr;
        bit          n_coll;
        bit          n_out_v;
        logic [15:0] n_out;
        SYS_X = 10'(x); SYS_Y = 10'(y); BG_DATA = bg; PIXEL_VALID = v;
        WRITE = wr; WRITE_ADDR = 2'(wa); WRITE_DATA = wd;
        FRAME_START = fs; COLLISION_CLR = clr;
        if (RST) begin
            win = -1;
            cnt = 0;
            for (int s = 0; s < N; s++) begin
                if (model_hit(s, x, y)) begin
                    cnt++;
                    if (win < 0) win = s;
                end
            end
            n_addr  = (win >= 0) ? act_i[win] * 1024 + (y - act_y[win]) * EDG + (x - act_x[win]) : 0;
            n_coll  = (v && cnt >= 2) ? 1'b1 : (clr ? 1'b0 : exp_coll);
            n_out_v = s1_valid;
            n_out   = (s1_hit && rom_mem[s1_addr] != 16'h0) ? rom_mem[s1_addr] : s1_bg;
            if (wr && wa < N) begin
                sh_y[wa] = int'(wd[31:22]); sh_x[wa] = int'(wd[21:12]);
                sh_f[wa] = int'(wd[11:6]);  sh_i[wa] = int'(wd[5:0]);
            end
            if (fs) begin
                act_y = sh_y; act_x = sh_x; act_f = sh_f; act_i = sh_i;
            end
            s1_valid = v; s1_hit = (win >= 0); s1_addr = n_addr; s1_bg = bg;
            @(negedge CLK);
            exp_addr = n_addr; exp_coll = n_coll; exp_out_v = n_out_v; exp_out = n_out;
            force_zero = 0;
        end else begin
            @(negedge CLK);
        end
        checkOutput();
    endtask

    task automatic pix(input int x, input int y, input logic [15:0] bg);
        applyStimulus(x, y, bg, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_slot(input int a, input logic [31:0] d, input bit fs);
        applyStimulus(0, 0, 16'h0, 0, 1, a, d, fs, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i) ^ 16'h5A5A;
        rom_mem[16'h0D45] = 16'h1234;
        rom_mem[16'h154A] = 16'h0000;
        model_reset();
        #1 RST = 1'b0;
        idle();
        idle();
        check("reset_rom_addr_lit", 32'(ROM_ADDR), 32'h0);
        RST = 1'b1;

        // Empty bank: everything is background
        pix(10, 10, 16'hBEEF);
        check("scan_addr_lit", 32'(ROM_ADDR), 32'h0);
        pix(11, 10, 16'hCAFE);
        check("scan_out_lit", 32'(OUT_GRAPHIC_DATA), 32'hBEEF);
        for (int i = 0; i < 4; i++) pix(20 + i, 30, 16'(16'h0100 + i));

        // Single sprite, hit and just past its right edge
        wr_slot(0, desc(100, 200, 0, 3), 0);
        wr_slot(1, desc(0, 0, 63, 0), 1);
        pix(205, 110, 16'h1111);
        check("hit_addr_lit", 32'(ROM_ADDR), 32'h0D45);
        pix(232, 110, 16'h2222);
        check("hit_out_lit", 32'(OUT_GRAPHIC_DATA), 32'h1234);
        idle();
        check("edge_out_lit", 32'(OUT_GRAPHIC_DATA), 32'h2222);
        idle();
        check("bubble_valid_lit", 32'(OUT_VALID), 32'h0);

        // Double buffering
        wr_slot(0, desc(100, 300, 0, 3), 0);
        pix(205, 110, 16'h1111);
        pix(301, 110, 16'h5555);
        check("shadow_hold_lit", 32'(OUT_GRAPHIC_DATA), 32'h1234);
        idle();
        check("shadow_bg_lit", 32'(OUT_GRAPHIC_DATA), 32'h5555);
        wr_slot(0, desc(100, 400, 0, 3), 1);
        pix(405, 110, 16'h6666);
        check("fwd_addr_lit", 32'(ROM_ADDR), 32'h0D45);
        pix(205, 110, 16'h7777);
        idle();
        check("old_pos_bg_lit", 32'(OUT_GRAPHIC_DATA), 32'h7777);

        // Priority, transparency and collision
        wr_slot(1, desc(40, 40, 0, 5), 0);
        wr_slot(2, desc(45, 45, 0, 7), 1);
        pix(50, 50, 16'h3333);
        check("prio_addr_lit", 32'(ROM_ADDR), 32'h154A);
        check("coll_set_lit", 32'(COLLISION), 32'h1);
        idle();
        check("transp_bg_lit", 32'(OUT_GRAPHIC_DATA), 32'h3333);
        wr_slot(1, desc(40, 40, 63, 5), 1);
        check("coll_fs_keep_lit", 32'(COLLISION), 32'h1);
        pix(50, 50, 16'h3333);
        check("fallthru_addr_lit", 32'(ROM_ADDR), 32'h1CA5);
        idle();
        check("fallthru_out_lit", 32'(OUT_GRAPHIC_DATA), 32'h46FF);
        wr_slot(1, desc(40, 40, 0, 5), 1);
        applyStimulus(50, 50, 16'h3333, 1, 0, 0, 0, 0, 1);
        check("coll_set_wins_lit", 32'(COLLISION), 32'h1);
        applyStimulus(0, 0, 16'h0, 1, 0, 0, 0, 0, 1);
        check("coll_clear_lit", 32'(COLLISION), 32'h0);

        // Clipping at the right edge of the screen
        wr_slot(3, desc(0, 1020, 0, 9), 1);
        pix(2, 5, 16'h4444);
        check("clip_addr_lit", 32'(ROM_ADDR), 32'h0);
        pix(1022, 5, 16'h8888);
        check("clip_hit_addr_lit", 32'(ROM_ADDR), 32'h24A2);
        check("clip_out_lit", 32'(OUT_GRAPHIC_DATA), 32'h4444);
        idle();
        check("clip_rom_out_lit", 32'(OUT_GRAPHIC_DATA), 32'h7EF8);

        // Sweep across slot 0's horizontal extent with bubbles
        for (int x = 396; x < 436; x += 3) begin
            applyStimulus(x, 110, 16'(x * 7), (x % 4) != 0, 0, 0, 0, 0, 0);
        end

        // Asynchronous reset mid-line
        pix(50, 50, 16'h3333);
        pix(405, 110, 16'h9999);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("rst_addr_lit", 32'(ROM_ADDR), 32'h0);
        check("rst_valid_lit", 32'(OUT_VALID), 32'h0);
        check("rst_data_lit", 32'(OUT_GRAPHIC_DATA), 32'h0);
        check("rst_coll_lit", 32'(COLLISION), 32'h0);
        model_reset();
        pix(405, 110, 16'h9999);
        RST = 1'b1;
        pix(405, 110, 16'hAAAA);
        check("post_rst_addr_lit", 32'(ROM_ADDR), 32'h0);
        check("post_rst_valid_lit", 32'(OUT_VALID), 32'h0);
        pix(1022, 5, 16'hBBBB);
        check("post_rst_out_lit", 32'(OUT_GRAPHIC_DATA), 32'hAAAA);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
